bp_tlb_miss_handler: RTL

Hardware page-table walker on the fill side of the TLB. It accepts a single outstanding miss (`miss_v`/`miss_vtag`) from a `bp_tlb` instance and walks an Sv39-style radix page table through a valid/ready memory read port. It then either writes the resulting leaf entry back into the TLB through its `v_i & w_i` fill path, or reports a page fault. It sits between the TLB and the cache/memory read port owned by the pipeline stage that hosts the TLB.

---
 rtl/bp_tlb_miss_handler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/bp_tlb_miss_handler.sv
// bp_tlb_miss_handler: Sv39-style radix page-table walker on the bp_tlb fill side.
// Latency: miss -> first PTE request 1 cycle, 2 cycles per level at zero stall, fill/fault strobe 1 cycle after the deciding PTE.
// Backpressure: one PTE read outstanding, held stable until mem_ready_i; misses are taken only while ready_o.
// Build option: define BP_TLB_MISS_HANDLER_A_CHECK_EN to fault on leaf PTEs whose accessed bit is clear.
module bp_tlb_miss_handler #(
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int paddr_width_p = 40,
  parameter int levels_p      = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [ptag_width_p-1:0]   satp_ppn_i,
  input  logic                      miss_v_i,
  input  logic [vtag_width_p-1:0]   miss_vtag_i,
  output logic                      ready_o,
  output logic                      mem_v_o,
  output logic [paddr_width_p-1:0]  mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_v_i,
  input  logic [63:0]               mem_data_i,
  output logic                      tlb_w_v_o,
  output logic [vtag_width_p-1:0]   tlb_vtag_o,
  output logic [ptag_width_p+3:0]   tlb_entry_o,
  output logic                      fault_v_o,
  output logic [vtag_width_p-1:0]   fault_vtag_o
);

  localparam int lvl_width_lp = (levels_p > 1) ? $clog2(levels_p) : 1;
  localparam logic [lvl_width_lp-1:0] top_level_lp = lvl_width_lp'(levels_p - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_REQ,
    S_WAIT_RSP,
    S_WRITE,
    S_FAULT,
    S_DRAIN
  } state_e;

  state_e                     r_state;
  logic                       r_ready;
  logic                       r_mem_v;
  logic                       r_tlb_w_v;
  logic                       r_fault_v;
  logic [paddr_width_p-1:0]   r_mem_addr;
  logic [vtag_width_p-1:0]    r_vtag;
  logic [ptag_width_p+3:0]    r_entry;
  logic [lvl_width_lp-1:0]    r_level;

  // PTE field decode of the response currently on mem_data_i
  logic                       w_pte_v;
  logic                       w_pte_r;
  logic                       w_pte_w;
  logic                       w_pte_x;
  logic                       w_pte_u;
  logic                       w_pte_a;
  logic [ptag_width_p-1:0]    w_pte_ppn;
  logic [ptag_width_p-1:0]    w_low_mask;
  logic [ptag_width_p-1:0]    w_vtag_ext;
  logic [ptag_width_p-1:0]    w_leaf_ptag;
  logic [lvl_width_lp-1:0]    w_level_dn;
  logic [vtag_width_p-1:0]    w_vtag_shift;
  logic [8:0]                 w_vpn_dn;
  logic [8:0]                 w_vpn_top;
  logic                       w_invalid;
  logic                       w_leaf;
  logic                       w_misaligned;
  logic                       w_a_fault;
  logic                       w_leaf_fault;
  logic                       w_unused_pte;

  assign w_pte_v   = mem_data_i[0];
  assign w_pte_r   = mem_data_i[1];
  assign w_pte_w   = mem_data_i[2];
  assign w_pte_x   = mem_data_i[3];
  assign w_pte_u   = mem_data_i[4];
  assign w_pte_a   = mem_data_i[6];
  assign w_pte_ppn = mem_data_i[ptag_width_p+9:10];

  // Reserved, D, G and RSW bits play no part in the walk.
  assign w_unused_pte = ^{mem_data_i[63:ptag_width_p+10], mem_data_i[9:7], mem_data_i[5], w_pte_a};

  // Write-only (R=0, W=1) is a reserved encoding and faults like an invalid PTE.
  assign w_invalid = ~w_pte_v | (~w_pte_r & w_pte_w);
  assign w_leaf    = w_pte_r | w_pte_x;

  // Low 9*level PPN bits: must be zero for a superpage and are filled from the VPN.
  assign w_low_mask   = (ptag_width_p'(1) << (9 * r_level)) - ptag_width_p'(1);
  assign w_vtag_ext   = ptag_width_p'(r_vtag);
  assign w_leaf_ptag  = (w_pte_ppn & ~w_low_mask) | (w_vtag_ext & w_low_mask);
  assign w_misaligned = |(w_pte_ppn & w_low_mask);

`ifdef BP_TLB_MISS_HANDLER_A_CHECK_EN
  // Software manages the accessed bit, so an un-accessed leaf traps to it.
  assign w_a_fault = ~w_pte_a;
`else
  assign w_a_fault = 1'b0;
`endif

  assign w_leaf_fault = w_misaligned | w_a_fault;

  // VPN slices: top level for a fresh miss, next level down while descending.
  assign w_level_dn   = r_level - lvl_width_lp'(1);
  assign w_vtag_shift = r_vtag >> (9 * w_level_dn);
  assign w_vpn_dn     = w_vtag_shift[8:0];
  assign w_vpn_top    = miss_vtag_i[vtag_width_p-1 -: 9];

  // Walk FSM: state and every registered output advance together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_mem_v    <= 1'b0;
      r_tlb_w_v  <= 1'b0;
      r_fault_v  <= 1'b0;
      r_mem_addr <= '0;
      r_vtag     <= '0;
      r_entry    <= '0;
      r_level    <= '0;
    end else begin
      r_tlb_w_v <= 1'b0;
      r_fault_v <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!flush_i && miss_v_i) begin
            r_state    <= S_SEND_REQ;
            r_ready    <= 1'b0;
            r_mem_v    <= 1'b1;
            r_vtag     <= miss_vtag_i;
            r_level    <= top_level_lp;
            r_mem_addr <= {satp_ppn_i, w_vpn_top, 3'b000};
          end
        end
        S_SEND_REQ: begin
          if (flush_i) begin
            r_mem_v <= 1'b0;
            if (mem_ready_i) begin
              // Request already accepted: its response must still be absorbed.
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end else if (mem_ready_i) begin
            r_mem_v <= 1'b0;
            r_state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (flush_i) begin
            if (mem_v_i) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem_v_i) begin
            if (w_invalid) begin
              r_state   <= S_FAULT;
              r_fault_v <= 1'b1;
            end else if (w_leaf) begin
              if (w_leaf_fault) begin
                r_state   <= S_FAULT;
                r_fault_v <= 1'b1;
              end else begin
                r_state   <= S_WRITE;
                r_tlb_w_v <= 1'b1;
                r_entry   <= {w_leaf_ptag, w_pte_u, w_pte_x, w_pte_w, w_pte_r};
              end
            end else if (r_level == '0) begin
              // Pointer at the last level has nowhere to go.
              r_state   <= S_FAULT;
              r_fault_v <= 1'b1;
            end else begin
              r_state    <= S_SEND_REQ;
              r_mem_v    <= 1'b1;
              r_level    <= w_level_dn;
              r_mem_addr <= {w_pte_ppn, w_vpn_dn, 3'b000};
            end
          end
        end
        S_WRITE, S_FAULT: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_DRAIN: begin
          if (mem_v_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_mem_v <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign mem_v_o      = r_mem_v;
  assign mem_addr_o   = r_mem_addr;
  assign tlb_vtag_o   = r_vtag;
  assign fault_vtag_o = r_vtag;
  assign tlb_entry_o  = r_entry;
  // A flush landing on the strobe cycle cancels it so no stale entry survives an sfence.
  assign tlb_w_v_o    = r_tlb_w_v & ~flush_i;
  assign fault_v_o    = r_fault_v & ~flush_i;

endmodule
